// File: rtl/avl_mem_writer_if.sv
// Avalon-MM write-master bus bundle: the master drives the request,
// the slave answers with waitrequest.
interface avl_mem_writer_if #(
    parameter int unsigned AVL_AW = 32,
    parameter int unsigned DW     = 32
) ();
    logic [AVL_AW-1:0] avm_address;
    logic              avm_write;
    logic [DW-1:0]     avm_writedata;
    logic [DW/8-1:0]   avm_byteenable;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest
    );
endinterface

// File: rtl/avl_mem_writer.sv
// Drains len words of the dual-port buffer to Avalon memory at base_addr + 4*i, hiding the
// buffer's 2-cycle read latency behind a 4-entry credit-controlled prefetch FIFO.
module avl_mem_writer #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 32,
    parameter int unsigned AVL_AW  = 32,
    parameter int unsigned FIFO_DP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AVL_AW-1:0] base_addr,
    input  logic [AW:0]       len,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     raddr,
    input  logic [DW-1:0]     data_out,
    avl_mem_writer_if.master  avm
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(FIFO_DP);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [AVL_AW-1:0] base_q, base_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic              busy_q, done_q;

    // rd_vld_q marks the cycle raddr is on the bus; pipe_q[1] lines up with valid data_out.
    logic              rd_vld_q;
    logic [1:0]        pipe_q;

    logic [DW-1:0]     fifo_mem_q [FIFO_DP];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       fifo_cnt_q;

    logic              push, pop, issue, avm_write_w;
    logic [3:0]        credit_used;

    assign push        = pipe_q[1];
    assign avm_write_w = (fifo_cnt_q != '0);
    assign pop         = avm_write_w & ~avm.avm_waitrequest;

    // Words committed after this cycle: reads in flight plus FIFO occupancy, net of the pop.
    assign credit_used = 4'(rd_vld_q) + 4'(pipe_q[0]) + 4'(pipe_q[1]) + 4'(fifo_cnt_q)
                       - 4'(pop);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        raddr_d  = raddr_q;
        issue    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Word 0 is read on the start cycle so it reaches the bus in cycle 4.
                    base_d   = base_addr;
                    len_d    = len;
                    wr_cnt_d = '0;
                    issue    = (len != '0);
                    rd_cnt_d = CW'(issue);
                    raddr_d  = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                issue = (rd_cnt_q < len_q) && (credit_used < 4'(FIFO_DP));
                if (issue) begin
                    raddr_d  = rd_cnt_q[AW-1:0];
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (pop) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
                if (wr_cnt_d == len_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            base_q     <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            raddr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
            pipe_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            raddr_q    <= raddr_d;
            busy_q     <= (state_d == StRun);
            done_q     <= (state_d == StDone);
            rd_vld_q   <= issue;
            pipe_q     <= {pipe_q[0], rd_vld_q};
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            fifo_cnt_q <= fifo_cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= data_out;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign raddr = raddr_q;

    assign avm.avm_write      = avm_write_w;
    assign avm.avm_writedata  = avm_write_w ? fifo_mem_q[rd_ptr_q] : '0;
    assign avm.avm_address    = base_q + AVL_AW'({wr_cnt_q, 2'b00});
    assign avm.avm_byteenable = avm_write_w ? '1 : '0;

endmodule

// File: doc/avl_mem_writer.md
# avl_mem_writer

Avalon-MM write master that drains a contiguous region of the on-chip dual-port buffer to external memory. It sits directly downstream of the buffer's read port. It issues buffer read addresses and absorbs the buffer's fixed 2-cycle read latency in a 4-entry prefetch FIFO. It then writes one word per accepted Avalon transfer to `base_addr + 4*i`. Used by the CNN accelerator to write layer results back to DDR.

## Interface
Parameters:
- `AW`, 12, buffer word-address width
- `DW`, 32, data width; must be 32 (byte addressing assumes 4-byte words)
- `AVL_AW`, 32, Avalon byte-address width
- `FIFO_DP`, 4, prefetch FIFO depth; fixed at 4

Ports:
- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-low reset (sampled on rising `clk`; 0 = reset)
- `start`  in  1  one-cycle request; accepted only in IDLE
- `base_addr`  in  AVL_AW  external byte address of word 0; latched on accepted `start`
- `len`  in  AW+1  number of words, 0..2^AW; latched on accepted `start`
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the last word has been accepted
- `raddr`  out  AW  buffer read address
- `data_out`  in  DW  buffer read data; valid exactly 2 cycles after `raddr` is driven
- `avm_address`  out  AVL_AW  Avalon byte address
- `avm_write`  out  1  Avalon write request
- `avm_writedata`  out  DW  Avalon write data
- `avm_byteenable`  out  DW/8  constant all-ones while `avm_write` is high, else 0
- `avm_waitrequest`  in  1  Avalon slave stall

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE:** On `start`=1, latch `base_addr`/`len`, clear the issue counter `rd_cnt` and the accept counter `wr_cnt`, then go to RUN. `start` is ignored in RUN and DONE.
- **RUN, read side:** Issue a read (`raddr` <= `rd_cnt`, `rd_cnt`++) in a cycle iff `rd_cnt < len` and (reads in flight + FIFO occupancy − pop this cycle) < 4.
  - A 2-stage valid shift register tracks reads in flight.
  - When a read's valid bit reaches stage 2, `data_out` is pushed into the FIFO.
  - The FIFO never overflows. Pushes while full are a design error; the bench asserts they never occur.
- **RUN, write side:**
  - `avm_write` = FIFO non-empty.
  - `avm_writedata` = FIFO head.
  - `avm_address` = latched base + 4*`wr_cnt`, computed modulo 2^AVL_AW, so the address wraps silently.
  - A transfer is accepted when `avm_write`=1 and `avm_waitrequest`=0. On acceptance, pop the FIFO and increment `wr_cnt`.
  - While `avm_waitrequest`=1, `avm_address`, `avm_writedata` and `avm_write` hold stable.
- RUN → DONE when `wr_cnt` reaches `len`.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then go to IDLE.
- **`len`=0:** RUN goes straight to DONE. No reads are issued and no writes are made.
- **`len`=2^AW:** reads cover addresses 0..2^AW−1. `rd_cnt` is AW+1 bits wide, so the full buffer is readable without counter wrap.

## Timing
- All outputs are registered except `avm_write`, `avm_writedata`, `avm_address` and `avm_byteenable`, which are driven directly from registered FIFO and counter state.
- **Reset values:** `busy`=0, `done`=0, `raddr`=0, `avm_write`=0, `avm_address`=0, `avm_writedata`=0, `avm_byteenable`=0. The FIFO is emptied, the valid pipeline is cleared and the FSM returns to IDLE.
- Reset asserted mid-transfer aborts the transfer immediately:
  - no `done` pulse;
  - `avm_write` is 0 in the cycle after the reset edge.
- **Latency** (`start` high in cycle 0):
  - cycle 1: `busy`=1, `raddr`=0;
  - cycle 3: `data_out` for word 0 is valid;
  - cycle 4: `avm_write`=1 with word 0.
- **Throughput:** with `avm_waitrequest` tied 0, one word is accepted per cycle. For N≥1 words, the last accept is in cycle N+3 and `done` is high in cycle N+4.
- **`len`=0:** `done` is high in cycle 2.
- **Backpressure:**
  - reads stop within the credit rule, so at most 4 words are buffered (in flight + FIFO);
  - when waitrequest drops, the stream resumes at one accept per cycle with no bubble.

## Test plan
- **Basic transfer:** buffer preloaded with 0x100+i for i=0..15; `len`=16, `base_addr`=0x1000_0000, waitrequest=0.
  - 16 writes at addresses 0x1000_0000..0x1000_003C with data 0x100..0x10F, in order;
  - `done` high in cycle 20.
- **`len`=0:** `start` → no `avm_write` ever; `done` high in cycle 2; `busy` high only in cycle 1.
- **Backpressure:** `len`=32, waitrequest random at 50%, plus one 20-cycle stall.
  - all 32 words written exactly once, in order;
  - address and data stable throughout every stall;
  - FIFO-overflow assertion never fires.
- **Full buffer:** `len`=4096, `base_addr`=0xFFFF_FFF0.
  - addresses wrap to 0x0000_0000 after 4 words;
  - 4096 writes total; `done` at cycle 4100.
- **Start ignored while busy:** a second `start` pulse with different `base_addr`/`len` during RUN has no effect on the ongoing transfer; exactly one `done` pulse.
- **Reset mid-transfer:** `rst`=0 in cycle 10 of a 16-word transfer.
  - all outputs at reset values from the next cycle; no `done`;
  - a subsequent `start` with `len`=4 completes normally.
